// File: rtl/port_uart_tx_if.sv
// Core output port value in; UART line and frame status out.
// slave = transmitter side, master = core/host side.
interface port_uart_tx_if;
    logic [15:0] portIn;
    logic        txOut;
    logic        busyOut;
    logic        pendingOut;
    logic        dropOut;

    modport master (
        output portIn,
        input  txOut,
        input  busyOut,
        input  pendingOut,
        input  dropOut
    );

    modport slave (
        input  portIn,
        output txOut,
        output busyOut,
        output pendingOut,
        output dropOut
    );
endinterface

// File: rtl/port_uart_tx.sv
// Sends each new 16-bit port value as two UART 8N1 bytes (low, high); start edge one clock after change.
// No backpressure: one pending slot, a newer change overwrites it and pulses dropOut.
module port_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic          clkIn,
    input  logic          resetIn,
    port_uart_tx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [15:0]      last_seen;
    logic [15:0]      shreg;
    logic [15:0]      pend_dat;
    logic             pend_vld;
    logic             byte_sel;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] baud_cnt;
    logic             tx;
    logic             drop;

    logic             change;
    logic             bit_end;
    logic             frame_end;
    logic [3:0]       next_idx;

    always_comb begin
        change    = (bus.portIn != last_seen);
        bit_end   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
        frame_end = (state == STOP) && byte_sel && bit_end;
        next_idx  = {byte_sel, bit_idx + 3'd1};
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state     <= IDLE;
            last_seen <= '0;
            shreg     <= '0;
            pend_dat  <= '0;
            pend_vld  <= 1'b0;
            byte_sel  <= 1'b0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            tx        <= 1'b1;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (change) begin
                last_seen <= bus.portIn;
            end
            baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (change) begin
                        shreg    <= bus.portIn;
                        byte_sel <= 1'b0;
                        state    <= START;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[{byte_sel, 3'd0}];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[next_idx];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            state    <= START;
                            tx       <= 1'b0;
                        end else if (pend_vld) begin
                            shreg    <= pend_dat;
                            byte_sel <= 1'b0;
                            state    <= START;
                            tx       <= 1'b0;
                        end else if (change) begin
                            shreg    <= bus.portIn;
                            byte_sel <= 1'b0;
                            state    <= START;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase

            // At the frame boundary the buffered value goes out first and a
            // coincident change takes its place without counting as a drop.
            if (frame_end && pend_vld) begin
                if (change) begin
                    pend_dat <= bus.portIn;
                end else begin
                    pend_vld <= 1'b0;
                end
            end else if ((state != IDLE) && change && !frame_end) begin
                pend_dat <= bus.portIn;
                pend_vld <= 1'b1;
                drop     <= pend_vld;
            end
        end
    end

    assign bus.txOut      = tx;
    assign bus.busyOut    = (state != IDLE);
    assign bus.pendingOut = pend_vld;
    assign bus.dropOut    = drop;

endmodule
